mem_arbiter: RTL

- Shares one SRAM-like memory port between the instruction-fetch requester and the data requester. Both requesters present physical addresses produced by the address-translation stage.
- Serialises requests with one outstanding transaction at a time, latches request attributes, and routes each response back to the requester that owns the transaction.
- Carries the per-request uncached flag (kseg1 accesses) to the memory side unchanged so the downstream cache/bridge can bypass.

---
 rtl/mem_arbiter_if.sv | 59 +++++
 rtl/mem_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter bus bundle: inst/data requester ports, downstream memory port, busy.
// slave = arbiter side, master = requesters plus memory model side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_uncached;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_uncached;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [1:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_uncached;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  inst_req, inst_addr, inst_uncached,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr,
    input  data_wdata, data_uncached,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_size, mem_addr,
    output mem_wdata, mem_uncached,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output busy
  );

  modport master (
    output inst_req, inst_addr, inst_uncached,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr,
    output data_wdata, data_uncached,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_size, mem_addr,
    input  mem_wdata, mem_uncached,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Inst/data arbiter onto one SRAM-like port, one transaction in flight.
// Define ARB_RR_EN for round-robin; default is fixed data-over-inst priority.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic         clk,
  input logic         resetn,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_DATA
  } owner_t;

  state_t            state;
  owner_t            owner;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              unc_q;

  logic gnt_inst;
  logic gnt_data;
  logic idle;
  logic done;

  assign idle = (state == IDLE);

`ifdef ARB_RR_EN
  owner_t last_owner;

  // on contention the requester that did not win last time goes first
  always_comb begin
    gnt_data = bus.data_req &
               (!bus.inst_req || last_owner != OWN_DATA);
    gnt_inst = bus.inst_req && !gnt_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_owner <= OWN_DATA;
    end else if (idle && gnt_data) begin
      last_owner <= OWN_DATA;
    end else if (idle && gnt_inst) begin
      last_owner <= OWN_INST;
    end
  end
`else
  always_comb begin
    gnt_data = bus.data_req;
    gnt_inst = bus.inst_req && !bus.data_req;
  end
`endif

  // completion: WAIT response, or accept+response in the same ADDR cycle
  assign done = bus.mem_data_ok &&
                ((state == WAIT) ||
                 (state == ADDR && bus.mem_addr_ok));

  assign bus.inst_addr_ok = idle && gnt_inst;
  assign bus.data_addr_ok = idle && gnt_data;
  assign bus.inst_data_ok = done && (owner == OWN_INST);
  assign bus.data_data_ok = done && (owner == OWN_DATA);
  assign bus.inst_rdata   = bus.mem_rdata;
  assign bus.data_rdata   = bus.mem_rdata;

  assign bus.mem_req      = (state == ADDR);
  assign bus.mem_wr       = wr_q;
  assign bus.mem_size     = size_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_uncached = unc_q;
  assign bus.busy         = !idle;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      owner   <= OWN_NONE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      unc_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            gnt_data: begin
              state   <= ADDR;
              owner   <= OWN_DATA;
              wr_q    <= bus.data_wr;
              size_q  <= bus.data_size;
              addr_q  <= bus.data_addr;
              wdata_q <= bus.data_wdata;
              unc_q   <= bus.data_uncached;
            end
            gnt_inst: begin
              state   <= ADDR;
              owner   <= OWN_INST;
              wr_q    <= 1'b0;
              size_q  <= 2'd2;
              addr_q  <= bus.inst_addr;
              wdata_q <= '0;
              unc_q   <= bus.inst_uncached;
            end
            default: ;
          endcase
        end
        ADDR: begin
          if (bus.mem_addr_ok) begin
            if (bus.mem_data_ok) begin
              state <= IDLE;
              owner <= OWN_NONE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.mem_data_ok) begin
            state <= IDLE;
            owner <= OWN_NONE;
          end
        end
        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule
